alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, multi-cycle successor to the single-cycle CPU ALU.
- Adds SUB with a registered ZERO flag for beq, a CARRY flag, an iterative shift-add multiplier and iterative shifts.
- Uses a START/BUSY/DONE handshake so the control unit can stall the pipeline while a multi-cycle op runs.
- Sits between the register file read ports and the writeback mux.

Parameters:
- WIDTH, 8, operand/result width in bits (≥4).
- SHW, $clog2(WIDTH)+1, width of the shift-amount field taken from DATA2.

Ports:
- CLK  input  1  rising-edge clock
- RESET  input  1  synchronous reset, active-high
- START  input  1  launch an operation; accepted only when BUSY=0
- SELECT  input  3  opcode, sampled at an accepted START
- DATA1  input  WIDTH  operand A (shift source)
- DATA2  input  WIDTH  operand B (shift amount in DATA2[SHW-1:0])
- RESULT  output  WIDTH  registered result, held until the next completion
- ZERO  output  1  registered; 1 iff completed RESULT==0
- CARRY  output  1  registered; ADD carry-out, SUB borrow, MUL high-half-nonzero, else 0
- BUSY  output  1  high while a multi-cycle op is iterating
- DONE  output  1  one-cycle pulse when RESULT/ZERO/CARRY update

Behaviour:
- Clock and reset: one clock (CLK). Synchronous, active-high reset (RESET), sampled on the CLK rising edge.
- Reset values: RESULT=0, ZERO=0, CARRY=0, BUSY=0, DONE=0, state=IDLE.
  - Reset mid-operation aborts the op; no DONE is produced for it.
- Opcodes:
  - 000 FWD: DATA2.
  - 001 ADD: DATA1+DATA2; CARRY = bit WIDTH of the sum.
  - 010 AND.
  - 011 OR.
  - 100 SUB: DATA1-DATA2 mod 2^WIDTH; CARRY = borrow (DATA1<DATA2 unsigned).
  - 101 MUL: unsigned, low WIDTH bits to RESULT.
  - 110 SLL by k.
  - 111 SRA by k.
- Shift amount: k = DATA2[SHW-1:0], clamped to WIDTH.
  - SLL with k≥WIDTH gives 0.
  - SRA with k≥WIDTH gives all copies of DATA1 MSB.
- FSM states and transitions:
  - IDLE: START with a single-cycle op (000–100) → DONE state; RESULT/flags written at that edge.
  - IDLE: START with MUL → MUL state; START with a shift and k>0 → SHIFT state; START with a shift and k=0 → DONE state, RESULT=DATA1.
  - MUL: one shift-add step per cycle for WIDTH cycles, using a 2·WIDTH-bit accumulator; then → DONE state.
  - SHIFT: one bit per cycle, k cycles; then → DONE state.
  - DONE: DONE=1 for exactly one cycle; → IDLE, or accepts a new START (back-to-back issue).
- Latency, with START sampled at edge n:
  - single-cycle ops and k=0 shifts: DONE high in cycle n+1;
  - MUL: DONE high at n+WIDTH+1;
  - shifts: DONE high at n+k+1.
- BUSY is high in the MUL and SHIFT states only. START while BUSY=1 is ignored; there is no queueing.
- Operands and opcode are latched at an accepted START. DATA1/DATA2/SELECT changes during BUSY have no effect.
- RESULT, ZERO and CARRY change only in the cycle DONE rises; otherwise they hold.

Optional Feature:
- Macro: ALU_MUL_EN.
- Defined: opcode 101 runs the iterative multiplier as described above.
- Undefined: no multiplier or accumulator logic is synthesised. Opcode 101 completes as a single-cycle op with RESULT=0, ZERO=1, CARRY=0, and BUSY is never asserted for it.

Test Plan:
- RESET held 2 cycles mid-MUL, then released → BUSY=0, DONE stays 0, RESULT=0, ZERO=0; a following START ADD 0x05+0x03 → DONE at n+1, RESULT=0x08, CARRY=0, ZERO=0.
- START ADD 0xF0+0x20 → RESULT=0x10, CARRY=1. START SUB 0x2A-0x2A → RESULT=0x00, ZERO=1, CARRY=0. START SUB 0x01-0x02 → RESULT=0xFF, CARRY=1.
- (ALU_MUL_EN) START MUL 0x0D×0x0B → BUSY high 8 cycles, DONE at n+9, RESULT=0x8F, CARRY=0. MUL 0x10×0x10 → RESULT=0x00, CARRY=1, ZERO=1.
- START SLL 0x81 by 3 → DONE at n+4, RESULT=0x08. SRA 0x80 by 2 → RESULT=0xE0. SRA 0x80 by 9 (clamped) → RESULT=0xFF. SLL by 0 → DONE at n+1, RESULT=DATA1.
- START MUL, then pulse START with ADD while BUSY=1 → ADD ignored, only the MUL DONE occurs. START issued in the DONE cycle → accepted, next DONE at the expected latency.
- Build without ALU_MUL_EN: START MUL 0x0D×0x0B → DONE at n+1, BUSY never high, RESULT=0x00, ZERO=1.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq -- multi-cycle ALU with a START/BUSY/DONE handshake.
//
// Single-cycle ops (FWD, ADD, AND, OR, SUB) finish one cycle after START.
// MUL is an iterative shift-add over WIDTH cycles. SLL/SRA shift one bit
// per cycle. RESULT, ZERO and CARRY are registered and change only on
// the cycle DONE pulses.
//
// Optional feature macro: ALU_MUL_EN
//   defined   : opcode 101 runs the iterative multiplier.
//   undefined : no multiplier hardware; opcode 101 completes in one cycle
//               with RESULT=0, ZERO=1, CARRY=0.
//
// Ports:
//   CLK     in   rising-edge clock
//   RESET   in   synchronous reset, active-high
//   START   in   launch an op; accepted only when BUSY=0
//   SELECT  in   [2:0] opcode, latched at an accepted START
//   DATA1   in   [WIDTH-1:0] operand A (shift source)
//   DATA2   in   [WIDTH-1:0] operand B (shift amount in DATA2[SHW-1:0])
//   RESULT  out  [WIDTH-1:0] registered result
//   ZERO    out  1 iff the completed RESULT is zero
//   CARRY   out  ADD carry-out, SUB borrow, MUL high-half nonzero, else 0
//   BUSY    out  high while MUL or SHIFT iterates
//   DONE    out  one-cycle pulse when RESULT/ZERO/CARRY update

module alu_seq #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH) + 1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [2:0]       SELECT,
    input  logic [WIDTH-1:0] DATA1,
    input  logic [WIDTH-1:0] DATA2,
    output logic [WIDTH-1:0] RESULT,
    output logic             ZERO,
    output logic             CARRY,
    output logic             BUSY,
    output logic             DONE
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_SHIFT,
        S_DONE
    } state_t;

    localparam logic [SHW-1:0] KMAX = SHW'(WIDTH);
    localparam logic [SHW-1:0] ONE  = SHW'(1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] result_nxt;
    logic             zero_nxt, carry_nxt;

    // Shared iteration counter: remaining shift bits or multiply steps.
    logic [SHW-1:0]   cnt, cnt_nxt;
    logic [WIDTH-1:0] sh_val, sh_val_nxt;
    logic             sh_left, sh_left_nxt;

    logic [WIDTH:0]   sum, diff;
    logic [SHW-1:0]   k;
    logic [WIDTH-1:0] sh_step;

    // Completion write: any path that finishes an op raises wr_en.
    logic             wr_en;
    logic [WIDTH-1:0] wr_val;
    logic             wr_carry;

`ifdef ALU_MUL_EN
    logic [2*WIDTH-1:0] acc, acc_nxt, mcand, mcand_nxt, mul_sum;
    logic [WIDTH-1:0]   mplier, mplier_nxt;

    assign mul_sum = mplier[0] ? acc + mcand : acc;
`endif

    // Extra top bit gives ADD carry-out and SUB borrow directly.
    assign sum  = {1'b0, DATA1} + {1'b0, DATA2};
    assign diff = {1'b0, DATA1} - {1'b0, DATA2};

    // Shifting by more than WIDTH is indistinguishable from WIDTH.
    assign k = (DATA2[SHW-1:0] > KMAX) ? KMAX : DATA2[SHW-1:0];

    assign sh_step = sh_left ? {sh_val[WIDTH-2:0], 1'b0}
                             : {sh_val[WIDTH-1], sh_val[WIDTH-1:1]};

    assign BUSY = (state == S_MUL) || (state == S_SHIFT);
    assign DONE = (state == S_DONE);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state   <= S_IDLE;
            RESULT  <= '0;
            ZERO    <= 1'b0;
            CARRY   <= 1'b0;
            cnt     <= '0;
            sh_val  <= '0;
            sh_left <= 1'b0;
`ifdef ALU_MUL_EN
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
`endif
        end else begin
            state   <= state_nxt;
            RESULT  <= result_nxt;
            ZERO    <= zero_nxt;
            CARRY   <= carry_nxt;
            cnt     <= cnt_nxt;
            sh_val  <= sh_val_nxt;
            sh_left <= sh_left_nxt;
`ifdef ALU_MUL_EN
            acc     <= acc_nxt;
            mcand   <= mcand_nxt;
            mplier  <= mplier_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt   = state;
        result_nxt  = RESULT;
        zero_nxt    = ZERO;
        carry_nxt   = CARRY;
        cnt_nxt     = cnt;
        sh_val_nxt  = sh_val;
        sh_left_nxt = sh_left;
        wr_en       = 1'b0;
        wr_val      = '0;
        wr_carry    = 1'b0;
`ifdef ALU_MUL_EN
        acc_nxt     = acc;
        mcand_nxt   = mcand;
        mplier_nxt  = mplier;
`endif

        case (state)
            // DONE behaves like IDLE so a START in the DONE cycle issues
            // back-to-back.
            S_IDLE, S_DONE: begin
                state_nxt = S_IDLE;
                if (START) begin
                    case (SELECT)
                        3'b000: begin
                            wr_en  = 1'b1;
                            wr_val = DATA2;
                        end
                        3'b001: begin
                            wr_en    = 1'b1;
                            wr_val   = sum[WIDTH-1:0];
                            wr_carry = sum[WIDTH];
                        end
                        3'b010: begin
                            wr_en  = 1'b1;
                            wr_val = DATA1 & DATA2;
                        end
                        3'b011: begin
                            wr_en  = 1'b1;
                            wr_val = DATA1 | DATA2;
                        end
                        3'b100: begin
                            wr_en    = 1'b1;
                            wr_val   = diff[WIDTH-1:0];
                            wr_carry = diff[WIDTH];
                        end
                        3'b101: begin
`ifdef ALU_MUL_EN
                            acc_nxt    = '0;
                            mcand_nxt  = {{WIDTH{1'b0}}, DATA1};
                            mplier_nxt = DATA2;
                            cnt_nxt    = KMAX;
                            state_nxt  = S_MUL;
`else
                            wr_en = 1'b1;
`endif
                        end
                        default: begin
                            // 110 = SLL, 111 = SRA
                            if (k == '0) begin
                                wr_en  = 1'b1;
                                wr_val = DATA1;
                            end else begin
                                sh_val_nxt  = DATA1;
                                sh_left_nxt = ~SELECT[0];
                                cnt_nxt     = k;
                                state_nxt   = S_SHIFT;
                            end
                        end
                    endcase
                end
            end

            S_MUL: begin
`ifdef ALU_MUL_EN
                acc_nxt    = mul_sum;
                mcand_nxt  = mcand << 1;
                mplier_nxt = mplier >> 1;
                cnt_nxt    = cnt - ONE;
                // Last step commits straight from the adder output.
                if (cnt == ONE) begin
                    wr_en    = 1'b1;
                    wr_val   = mul_sum[WIDTH-1:0];
                    wr_carry = |mul_sum[2*WIDTH-1:WIDTH];
                end
`else
                state_nxt = S_IDLE;
`endif
            end

            S_SHIFT: begin
                sh_val_nxt = sh_step;
                cnt_nxt    = cnt - ONE;
                if (cnt == ONE) begin
                    wr_en  = 1'b1;
                    wr_val = sh_step;
                end
            end

            default: state_nxt = S_IDLE;
        endcase

        if (wr_en) begin
            result_nxt = wr_val;
            zero_nxt   = (wr_val == '0);
            carry_nxt  = wr_carry;
            state_nxt  = S_DONE;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq. A reference model pushes expected
// RESULT/ZERO/CARRY into a queue at each issued START; a monitor pops and
// compares whenever DONE pulses. Scenario tasks check latency, BUSY
// duration and the constants listed for each vector.

module tb_alu_seq;

    localparam int W   = 8;
    localparam int SHW = $clog2(W) + 1;

    logic         CLK    = 1'b0;
    logic         RESET  = 1'b1;
    logic         START  = 1'b0;
    logic [2:0]   SELECT = '0;
    logic [W-1:0] DATA1  = '0;
    logic [W-1:0] DATA2  = '0;
    logic [W-1:0] RESULT;
    logic         ZERO, CARRY, BUSY, DONE;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] res;
        logic         z;
        logic         c;
    } exp_t;

    typedef struct {
        logic [2:0]   sel;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         z;
        logic         c;
        int           lat;
    } vec_t;

    exp_t sbq[$];

    alu_seq #(.WIDTH(W), .SHW(SHW)) dut (
        .CLK(CLK), .RESET(RESET), .START(START), .SELECT(SELECT),
        .DATA1(DATA1), .DATA2(DATA2), .RESULT(RESULT), .ZERO(ZERO),
        .CARRY(CARRY), .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    function automatic int clamp_k(input logic [W-1:0] b);
        int k;
        k = int'(b[SHW-1:0]);
        if (k > W) k = W;
        return k;
    endfunction

    function automatic int exp_lat(input logic [2:0] sel, input logic [W-1:0] b);
        case (sel)
`ifdef ALU_MUL_EN
            3'd5: return W;
`endif
            3'd6, 3'd7: return clamp_k(b);
            default: return 0;
        endcase
    endfunction

    function automatic exp_t model(input logic [2:0] sel, input logic [W-1:0] a,
                                   input logic [W-1:0] b);
        exp_t e;
        logic [W:0] s;
        int k;
`ifdef ALU_MUL_EN
        logic [2*W-1:0] p;
`endif
        e.c = 1'b0;
        e.res = '0;
        k = clamp_k(b);
        case (sel)
            3'd0: e.res = b;
            3'd1: begin s = {1'b0, a} + {1'b0, b}; e.res = s[W-1:0]; e.c = s[W]; end
            3'd2: e.res = a & b;
            3'd3: e.res = a | b;
            3'd4: begin e.res = a - b; e.c = (a < b); end
            3'd5: begin
`ifdef ALU_MUL_EN
                p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                e.res = p[W-1:0];
                e.c = (p[2*W-1:W] != '0);
`else
                e.res = '0;
`endif
            end
            3'd6: e.res = (k >= W) ? '0 : W'(a << k);
            default: e.res = W'($signed(a) >>> k);
        endcase
        e.z = (e.res == '0);
        return e;
    endfunction

    // Scoreboard monitor plus hold check on the registered outputs.
    logic [W-1:0] prev_res = '0;
    logic         prev_z = 1'b0, prev_c = 1'b0, prev_rst = 1'b1;

    always @(negedge CLK) begin : monitor
        exp_t e;
        if (DONE) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: DONE with nothing outstanding, RESULT=%h", RESULT);
            end else begin
                e = sbq.pop_front();
                if ({RESULT, ZERO, CARRY} !== {e.res, e.z, e.c}) begin
                    errors++;
                    $display("FAIL scoreboard: got R=%h Z=%b C=%b, expected R=%h Z=%b C=%b",
                             RESULT, ZERO, CARRY, e.res, e.z, e.c);
                end
            end
        end else if (!RESET && !prev_rst) begin
            checks++;
            if ({RESULT, ZERO, CARRY} !== {prev_res, prev_z, prev_c}) begin
                errors++;
                $display("FAIL hold: outputs changed without DONE, got R=%h Z=%b C=%b, expected R=%h Z=%b C=%b",
                         RESULT, ZERO, CARRY, prev_res, prev_z, prev_c);
            end
        end
        prev_res = RESULT;
        prev_z   = ZERO;
        prev_c   = CARRY;
        prev_rst = RESET;
    end

    // Issue one op, scramble the inputs once it is accepted, then wait for
    // DONE. d = negedges after the accepting edge until DONE is seen.
    // With b2b set the caller is at the negedge of a DONE cycle and START is
    // raised right away. poke_at >= 0 pulses an ADD START while waiting.
    task automatic run_op(input logic [2:0] sel, input logic [W-1:0] a,
                          input logic [W-1:0] b, input bit b2b, input int poke_at,
                          output int d, output int busy, output bit ok);
        if (!b2b) begin
            @(posedge CLK);
            #1;
        end
        START  = 1'b1;
        SELECT = sel;
        DATA1  = a;
        DATA2  = b;
        sbq.push_back(model(sel, a, b));
        @(posedge CLK);
        #1;
        START  = 1'b0;
        SELECT = 3'($urandom);
        DATA1  = W'($urandom);
        DATA2  = W'($urandom);
        d = 0;
        busy = 0;
        @(negedge CLK);
        while (!DONE && d < 64) begin
            if (BUSY) busy++;
            if (d == poke_at) begin
                START  = 1'b1;
                SELECT = 3'b001;
                DATA1  = W'(5);
                DATA2  = W'(3);
            end else begin
                START = 1'b0;
            end
            d++;
            @(negedge CLK);
        end
        START = 1'b0;
        ok = DONE;
        if (!ok) sbq.delete();
    endtask

    task automatic test_reset();
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        checks++;
        if ({RESULT, ZERO, CARRY, BUSY, DONE} !== {{W{1'b0}}, 4'b0000}) begin
            errors++;
            $display("FAIL reset_state: got R=%h Z=%b C=%b B=%b D=%b, expected all 0",
                     RESULT, ZERO, CARRY, BUSY, DONE);
        end
        @(posedge CLK);
        #1;
        RESET = 1'b0;
    endtask

    task automatic test_reset_mid_op();
        int d, busy;
        bit ok;
        // Leave a nonzero RESULT behind so the reset clear is visible.
        run_op(3'b011, 8'h5A, 8'h00, 1'b0, -1, d, busy, ok);
        @(posedge CLK);
        #1;
        START = 1'b1;
`ifdef ALU_MUL_EN
        SELECT = 3'b101; DATA1 = 8'h0D; DATA2 = 8'h0B;
`else
        SELECT = 3'b110; DATA1 = 8'h81; DATA2 = 8'h07;
`endif
        @(posedge CLK);
        #1;
        START = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b0;
        @(negedge CLK);
        checks++;
        if ({RESULT, ZERO, CARRY, BUSY, DONE} !== {{W{1'b0}}, 4'b0000}) begin
            errors++;
            $display("FAIL reset_mid_op: got R=%h Z=%b C=%b B=%b D=%b, expected all 0",
                     RESULT, ZERO, CARRY, BUSY, DONE);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            checks++;
            if (BUSY !== 1'b0 || DONE !== 1'b0) begin
                errors++;
                $display("FAIL reset_abort: cycle %0d got B=%b D=%b, expected 0 0", i, BUSY, DONE);
            end
        end
        run_op(3'b001, 8'h05, 8'h03, 1'b0, -1, d, busy, ok);
        checks++;
        if (!ok || d !== 0 || {RESULT, ZERO, CARRY} !== {8'h08, 2'b00}) begin
            errors++;
            $display("FAIL add_after_reset: got ok=%b lat=%0d R=%h Z=%b C=%b, expected lat=0 R=08 Z=0 C=0",
                     ok, d, RESULT, ZERO, CARRY);
        end
    endtask

    // Table-driven vectors: inline constant and latency checks.
    task automatic run_table(input string name, input vec_t tv[$]);
        int d, busy;
        bit ok;
        foreach (tv[i]) begin
            run_op(tv[i].sel, tv[i].a, tv[i].b, 1'b0, -1, d, busy, ok);
            checks++;
            if (!ok || d !== tv[i].lat || busy !== tv[i].lat ||
                {RESULT, ZERO, CARRY} !== {tv[i].res, tv[i].z, tv[i].c}) begin
                errors++;
                $display("FAIL %s[%0d]: got ok=%b lat=%0d busy=%0d R=%h Z=%b C=%b, expected lat=%0d R=%h Z=%b C=%b",
                         name, i, ok, d, busy, RESULT, ZERO, CARRY,
                         tv[i].lat, tv[i].res, tv[i].z, tv[i].c);
            end
        end
    endtask

    task automatic test_alu_ops();
        vec_t tv[$];
        tv = '{
            '{3'b001, 8'hF0, 8'h20, 8'h10, 1'b0, 1'b1, 0},
            '{3'b100, 8'h2A, 8'h2A, 8'h00, 1'b1, 1'b0, 0},
            '{3'b100, 8'h01, 8'h02, 8'hFF, 1'b0, 1'b1, 0},
            '{3'b001, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 0},
            '{3'b000, 8'h33, 8'h5A, 8'h5A, 1'b0, 1'b0, 0},
            '{3'b010, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 0},
            '{3'b011, 8'hF0, 8'h0C, 8'hFC, 1'b0, 1'b0, 0}
        };
        run_table("alu", tv);
    endtask

    task automatic test_shift();
        vec_t tv[$];
        tv = '{
            '{3'b110, 8'h81, 8'h03, 8'h08, 1'b0, 1'b0, 3},
            '{3'b111, 8'h80, 8'h02, 8'hE0, 1'b0, 1'b0, 2},
            '{3'b111, 8'h80, 8'h09, 8'hFF, 1'b0, 1'b0, 8},
            '{3'b110, 8'h81, 8'h00, 8'h81, 1'b0, 1'b0, 0},
            '{3'b111, 8'h92, 8'h00, 8'h92, 1'b0, 1'b0, 0},
            '{3'b110, 8'h81, 8'h0F, 8'h00, 1'b1, 1'b0, 8},
            '{3'b111, 8'h40, 8'h07, 8'h00, 1'b1, 1'b0, 7},
            '{3'b110, 8'hA5, 8'hF2, 8'h94, 1'b0, 1'b0, 2}
        };
        run_table("shift", tv);
    endtask

    task automatic test_mul();
        vec_t tv[$];
`ifdef ALU_MUL_EN
        tv = '{
            '{3'b101, 8'h0D, 8'h0B, 8'h8F, 1'b0, 1'b0, 8},
            '{3'b101, 8'h10, 8'h10, 8'h00, 1'b1, 1'b1, 8},
            '{3'b101, 8'hFF, 8'hFF, 8'h01, 1'b0, 1'b1, 8},
            '{3'b101, 8'h00, 8'h37, 8'h00, 1'b1, 1'b0, 8}
        };
`else
        tv = '{
            '{3'b101, 8'h0D, 8'h0B, 8'h00, 1'b1, 1'b0, 0},
            '{3'b101, 8'h10, 8'h10, 8'h00, 1'b1, 1'b0, 0}
        };
`endif
        run_table("mul", tv);
    endtask

    task automatic test_busy_ignore();
        int d, busy;
        bit ok;
`ifdef ALU_MUL_EN
        run_op(3'b101, 8'h0D, 8'h0B, 1'b0, 2, d, busy, ok);
        checks++;
        if (!ok || d !== W || RESULT !== 8'h8F) begin
            errors++;
            $display("FAIL busy_ignore: got ok=%b lat=%0d R=%h, expected lat=%0d R=8f", ok, d, RESULT, W);
        end
`else
        run_op(3'b110, 8'h81, 8'h07, 1'b0, 2, d, busy, ok);
        checks++;
        if (!ok || d !== 7 || RESULT !== 8'h80) begin
            errors++;
            $display("FAIL busy_ignore: got ok=%b lat=%0d R=%h, expected lat=7 R=80", ok, d, RESULT);
        end
`endif
        repeat (6) @(negedge CLK);
        checks++;
        if (sbq.size() !== 0 || RESULT !== model(3'b101, 8'h0D, 8'h0B).res && RESULT !== 8'h80) begin
            errors++;
            $display("FAIL busy_ignore_drain: got queue=%0d R=%h, expected queue=0 and no new result",
                     sbq.size(), RESULT);
        end
    endtask

    task automatic test_back_to_back();
        int d, busy;
        bit ok;
        logic [2:0]   sel[5] = '{3'b001, 3'b100, 3'b110, 3'b101, 3'b111};
        logic [W-1:0] a[5]   = '{8'h11, 8'h40, 8'h03, 8'h07, 8'hC0};
        logic [W-1:0] b[5]   = '{8'h22, 8'h41, 8'h04, 8'h09, 8'h03};
        for (int i = 0; i < 5; i++) begin
            run_op(sel[i], a[i], b[i], (i != 0), -1, d, busy, ok);
            checks++;
            if (!ok || d !== exp_lat(sel[i], b[i])) begin
                errors++;
                $display("FAIL back_to_back[%0d]: got ok=%b lat=%0d, expected lat=%0d",
                         i, ok, d, exp_lat(sel[i], b[i]));
            end
        end
    endtask

    task automatic test_random();
        int d, busy;
        bit ok;
        logic [2:0]   sel;
        logic [W-1:0] a, b;
        for (int i = 0; i < 30; i++) begin
            sel = 3'($urandom);
            a   = W'($urandom);
            b   = W'($urandom);
            run_op(sel, a, b, ($urandom_range(0, 1) == 1), -1, d, busy, ok);
            checks++;
            if (!ok || d !== exp_lat(sel, b) || busy !== exp_lat(sel, b)) begin
                errors++;
                $display("FAIL random[%0d]: sel=%0d b=%h got ok=%b lat=%0d busy=%0d, expected %0d",
                         i, sel, b, ok, d, busy, exp_lat(sel, b));
            end
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_op();
        test_alu_ops();
        test_shift();
        test_mul();
        test_busy_ignore();
        test_back_to_back();
        test_random();
        repeat (4) @(negedge CLK);
        checks++;
        if (sbq.size() !== 0) begin
            errors++;
            $display("FAIL drain: got %0d outstanding results, expected 0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
